mult_apu_initiator: RTL

Core-side initiator for the shared integer multiplier, issuing requests to it and collecting its results. It accepts multiply requests from the core pipeline and drives the APU request/grant channel towards the shared multiplier. It tracks in-flight operations and their destination register addresses, and buffers the in-order responses. Results are presented to core writeback through a valid/ready port. It sits between the core EX stage and the APU interconnect of the cluster.

---
 rtl/mult_apu_initiator.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mult_apu_initiator.sv
// mult_apu_initiator
//   Core-side initiator for the shared integer multiplier. Accepts multiply
//   requests from the core EX stage, issues them on the APU req/gnt channel,
//   tracks destination registers of granted ops, buffers in-order responses
//   and presents them to core writeback through a valid/ready port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   core_*                   request from core (valid/ready, operator, operands,
//                            imm, subword, signed, waddr); core_illegal_o pulses
//                            one cycle after a rejected operator is accepted
//   apu_req_o/apu_gnt_i      request handshake; apu_op_o, apu_operands_o {c,b,a},
//                            apu_flags_o {signed, subword, imm}
//   apu_rvalid_i/apu_rdata_i in-order response, no backpressure
//   wb_*                     writeback valid/ready with waddr and result
//   busy_o                   any operation held or in flight
//
// Build option
//   MULT_APU_INIT_RESP_BYPASS_EN : when the result FIFO is empty, a response is
//   presented on the writeback port in the same cycle it arrives.

module mult_apu_initiator #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid_i,
  output logic        core_ready_o,
  input  logic [2:0]  core_operator_i,
  input  logic [31:0] core_op_a_i,
  input  logic [31:0] core_op_b_i,
  input  logic [31:0] core_op_c_i,
  input  logic [4:0]  core_imm_i,
  input  logic        core_subword_i,
  input  logic [1:0]  core_signed_i,
  input  logic [4:0]  core_waddr_i,
  output logic        core_illegal_o,
  output logic        apu_req_o,
  input  logic        apu_gnt_i,
  output logic [2:0]  apu_op_o,
  output logic [95:0] apu_operands_o,
  output logic [7:0]  apu_flags_o,
  input  logic        apu_rvalid_i,
  input  logic [31:0] apu_rdata_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_rdata_o,
  output logic        busy_o
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] r_credit;
  logic          r_iss_vld;
  logic [2:0]    r_iss_op;
  logic [95:0]   r_iss_opnd;
  logic [7:0]    r_iss_flags;
  logic [4:0]    r_iss_waddr;
  logic          r_illegal;

  logic [4:0]    r_tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0] r_tag_wp, r_tag_rp;
  logic [31:0]   r_res_mem [MAX_OUTSTANDING];
  logic [PW-1:0] r_res_wp, r_res_rp;
  logic [CW-1:0] r_res_cnt;
  // granted but not yet answered; anything beyond this is a spurious response
  logic [CW-1:0] r_inflight;

  logic w_gnt, w_accept, w_legal, w_acc, w_rv_ok, w_res_empty;
  logic w_wb_valid, w_wb_hs, w_res_push, w_res_pop;
  logic [31:0] w_rdata_head;

  assign w_gnt        = r_iss_vld & apu_gnt_i;
  assign core_ready_o = (r_credit != '0) && (!r_iss_vld || apu_gnt_i);
  assign w_accept     = core_valid_i & core_ready_o;
  assign w_legal      = ~core_operator_i[2];
  assign w_acc        = w_accept & w_legal;
  assign w_rv_ok      = apu_rvalid_i && (r_inflight != '0);
  assign w_res_empty  = (r_res_cnt == '0);

`ifdef MULT_APU_INIT_RESP_BYPASS_EN
  // Empty FIFO: show the response directly; store it only if wb can't take it now.
  assign w_wb_valid   = !w_res_empty || w_rv_ok;
  assign w_rdata_head = w_res_empty ? apu_rdata_i : r_res_mem[r_res_rp];
  assign w_res_push   = w_rv_ok && !(w_res_empty && wb_ready_i);
`else
  assign w_wb_valid   = !w_res_empty;
  assign w_rdata_head = r_res_mem[r_res_rp];
  assign w_res_push   = w_rv_ok;
`endif

  assign w_wb_hs   = w_wb_valid && wb_ready_i;
  assign w_res_pop = w_wb_hs && !w_res_empty;

  assign apu_req_o      = r_iss_vld;
  assign apu_op_o       = r_iss_op;
  assign apu_operands_o = r_iss_opnd;
  assign apu_flags_o    = r_iss_flags;
  assign core_illegal_o = r_illegal;
  assign busy_o         = (r_credit != MAX_C);
  assign wb_valid_o     = w_wb_valid;
  // heads are gated so stale memory contents never leak onto the port
  assign wb_waddr_o     = w_wb_valid ? r_tag_mem[r_tag_rp] : '0;
  assign wb_rdata_o     = w_wb_valid ? w_rdata_head : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit    <= MAX_C;
      r_iss_vld   <= 1'b0;
      r_iss_op    <= '0;
      r_iss_opnd  <= '0;
      r_iss_flags <= '0;
      r_iss_waddr <= '0;
      r_illegal   <= 1'b0;
      r_tag_wp    <= '0;
      r_tag_rp    <= '0;
      r_res_wp    <= '0;
      r_res_rp    <= '0;
      r_res_cnt   <= '0;
      r_inflight  <= '0;
    end else begin
      r_illegal <= w_accept & ~w_legal;

      // reload in the grant cycle gives back-to-back issue
      if (w_acc) begin
        r_iss_vld   <= 1'b1;
        r_iss_op    <= core_operator_i;
        r_iss_opnd  <= {core_op_c_i, core_op_b_i, core_op_a_i};
        r_iss_flags <= {core_signed_i, core_subword_i, core_imm_i};
        r_iss_waddr <= core_waddr_i;
      end else if (w_gnt) begin
        r_iss_vld <= 1'b0;
      end

      if (w_acc && !w_wb_hs)      r_credit <= r_credit - CW'(1);
      else if (!w_acc && w_wb_hs) r_credit <= r_credit + CW'(1);

      if (w_gnt)      r_tag_wp <= r_tag_wp + PW'(1);
      if (w_wb_hs)    r_tag_rp <= r_tag_rp + PW'(1);
      if (w_res_push) r_res_wp <= r_res_wp + PW'(1);
      if (w_res_pop)  r_res_rp <= r_res_rp + PW'(1);

      if (w_res_push && !w_res_pop)      r_res_cnt <= r_res_cnt + CW'(1);
      else if (!w_res_push && w_res_pop) r_res_cnt <= r_res_cnt - CW'(1);

      if (w_gnt && !w_rv_ok)      r_inflight <= r_inflight + CW'(1);
      else if (!w_gnt && w_rv_ok) r_inflight <= r_inflight - CW'(1);

      assert (!apu_rvalid_i || r_inflight != '0)
        else $warning("mult_apu_initiator: spurious apu_rvalid_i dropped");
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt)      r_tag_mem[r_tag_wp] <= r_iss_waddr;
    if (w_res_push) r_res_mem[r_res_wp] <= apu_rdata_i;
  end

endmodule
